// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg -- shared definitions for the instruction fetch unit.
//   XLEN          : datapath width (32)
//   ZERO_WORD     : all-zero word, used for the empty-slot address
//   PC_STEP       : PC increment between sequential fetches
//   OPCODE_OP_IMM : RV32I OP-IMM major opcode
//   INST_NOP      : canonical NOP encoding (addi x0,x0,0)
//   fetch_state_e : fetch FSM encodings (S_REQ, S_WAIT)
//   align_word()  : clears the two low address bits
package ifu_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b001_0011;

  // addi x0, x0, 0 : imm=0, rs1=x0, funct3=000, rd=x0, OP-IMM
  localparam logic [XLEN-1:0] INST_NOP = {12'd0, 5'd0, 3'b000, 5'd0, OPCODE_OP_IMM};

  typedef enum logic {
    S_REQ  = 1'b0,  // ready to issue a request at pc
    S_WAIT = 1'b1   // request granted, waiting for rvalid
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit feeding the if_id register.
// Owns the PC, keeps at most one memory request outstanding, holds one
// fetched instruction until downstream accepts it, and redirects on jumps
// from execute while discarding any in-flight response.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   jump_en_i/addr_i     redirect request (one-cycle pulse) and target
//   id_ready_i           downstream accepts inst_o this cycle
//   mem_req_o/addr_o     fetch request and address (address is always pc)
//   mem_gnt_i            memory accepts the request
//   mem_rvalid_i/rdata_i response valid and instruction word
//   inst_o/inst_addr_o   held instruction and its address (NOP_INST / 0 when empty)
//   inst_valid_o         output register holds a valid instruction
//   fetch_err_o          sticky misaligned-jump flag
//
// Build option: define IFU_MISALIGN_CHECK_EN to word-align jump targets and
// flag misaligned ones on fetch_err_o; otherwise targets pass through
// unmodified and fetch_err_o is tied low.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            id_ready_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_valid_o,
  output logic            fetch_err_o
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            drop;       // a response is still owed for a request issued before a jump

  logic            slot_free;
  logic            grant;
  logic            load;
  logic            consume;
  logic            drop_next;
  logic [XLEN-1:0] jump_target;

  // The slot is free next cycle if it is empty now or being drained now.
  assign slot_free = !inst_valid_o || id_ready_i;

  // Gated by rst_n so no request is presented while held in reset. While a
  // dropped response is pending no new request goes out, keeping the
  // single-outstanding rule across a redirect.
  assign mem_req_o  = rst_n && (state == S_REQ) && !drop && slot_free;
  assign mem_addr_o = pc;

  assign grant   = mem_req_o && mem_gnt_i;
  assign load    = (state == S_WAIT) && mem_rvalid_i && !drop;
  assign consume = inst_valid_o && id_ready_i;

  // On a jump, remember whether a response for the abandoned request is
  // still to come. A pending drop from an earlier jump is kept alive too.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    drop_next = 1'b0;
    if (state == S_WAIT) drop_next = !mem_rvalid_i;
    else                 drop_next = grant || (drop && !mem_rvalid_i);
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic jump_misaligned;

  assign jump_target     = align_word(jump_addr_i);
  assign jump_misaligned = jump_en_i && (jump_addr_i[1:0] != 2'b00);

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               fetch_err_o <= 1'b0;
    else if (jump_misaligned) fetch_err_o <= 1'b1;
  end
`else
  assign jump_target = jump_addr_i;
  assign fetch_err_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP_INST;
      inst_addr_o  <= ZERO_WORD;
    end else if (jump_en_i) begin
      // Redirect overrides everything, including a response or consume this cycle.
      state        <= S_REQ;
      pc           <= jump_target;
      drop         <= drop_next;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP_INST;
      inst_addr_o  <= ZERO_WORD;
    end else begin
      case (state)
        S_REQ: begin
          // Late responses in S_REQ are only meaningful as the owed one.
          if (drop && mem_rvalid_i) drop <= 1'b0;
          if (grant) begin
            pc    <= pc + PC_STEP;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      // pc already advanced on grant, so the response belongs to pc-4.
      if (load) begin
        inst_valid_o <= 1'b1;
        inst_o       <= mem_rdata_i;
        inst_addr_o  <= pc - PC_STEP;
      end else if (consume) begin
        inst_valid_o <= 1'b0;
        inst_o       <= NOP_INST;
        inst_addr_o  <= ZERO_WORD;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- directed testbench for ifu_fetch. A small memory model
// with configurable grant and response latency answers fetch requests;
// each scenario task drives stimulus and compares against hand-derived
// values. Build with IFU_MISALIGN_CHECK_EN to cover the alignment option.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        id_ready_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        fetch_err_o;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .id_ready_i   (id_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .fetch_err_o  (fetch_err_o)
  );

  // ---------------- memory model ----------------
  int          gnt_dly = 0;   // cycles a request waits before grant
  int          rv_dly  = 1;   // cycles from grant to rvalid
  int          req_wait = 0;
  int          rv_cnt = -1;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0020_8113;
      32'h0000_0008: return 32'h0030_8193;
      32'h0000_0100: return 32'h0050_0293;
      32'h0000_0200: return 32'h00a0_0513;
      32'h0000_0300: return 32'h00c0_0613;
      default:       return ~a;
    endcase
  endfunction

  assign mem_gnt_i    = mem_req_o && (req_wait >= gnt_dly);
  assign mem_rvalid_i = (rv_cnt == 0);
  assign mem_rdata_i  = mem_rvalid_i ? mem_word(pend_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wait  <= 0;
      rv_cnt    <= -1;
      pend_addr <= '0;
    end else begin
      if (mem_req_o && !mem_gnt_i) req_wait <= req_wait + 1;
      else                         req_wait <= 0;
      if (mem_gnt_i) begin
        pend_addr <= mem_addr_o;
        rv_cnt    <= rv_dly - 1;
      end else if (rv_cnt >= 0) begin
        rv_cnt <= rv_cnt - 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input int g, input int r);
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    id_ready_i  = 1'b1;
    gnt_dly     = g;
    rv_dly      = r;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    jump_en_i = 1'b0; id_ready_i = 1'b1; gnt_dly = 0; rv_dly = 1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", mem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", inst_valid_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr_o); end
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", fetch_err_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", mem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %0b want 1", mem_req_o); end
  endtask

  task automatic test_zero_wait();
    do_reset(0, 1);
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL zw_req0: got %0b/%h want 1/0", mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if ({mem_req_o, inst_valid_o} !== 2'b00) begin errors++; $display("FAIL zw_wait: got req=%0b valid=%0b want 0/0", mem_req_o, inst_valid_o); end
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h0010_0093, 32'h0}) begin errors++; $display("FAIL zw_inst0: got %0b/%h/%h want 1/00100093/0", inst_valid_o, inst_o, inst_addr_o); end
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h4}) begin errors++; $display("FAIL zw_req4: got %0b/%h want 1/4", mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if ({mem_req_o, inst_valid_o} !== 2'b00) begin errors++; $display("FAIL zw_consumed: got req=%0b valid=%0b want 0/0", mem_req_o, inst_valid_o); end
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h0020_8113, 32'h4}) begin errors++; $display("FAIL zw_inst1: got %0b/%h/%h want 1/00208113/4", inst_valid_o, inst_o, inst_addr_o); end
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h8}) begin errors++; $display("FAIL zw_req8: got %0b/%h want 1/8", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_backpressure();
    do_reset(0, 1);
    next_cycle();
    id_ready_i = 1'b0;
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, mem_req_o} !== {1'b1, 32'h0010_0093, 1'b0}) begin errors++; $display("FAIL bp_hold: got %0b/%h req=%0b want 1/00100093/0", inst_valid_o, inst_o, mem_req_o); end
    next_cycle();
    next_cycle();
    checks++; if ({inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o} !== {1'b1, 32'h0, 1'b0, 32'h4}) begin errors++; $display("FAIL bp_still: got %0b/%h req=%0b/%h want 1/0/0/4", inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o); end
    id_ready_i = 1'b1;
    #1;
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h4}) begin errors++; $display("FAIL bp_release_req: got %0b/%h want 1/4", mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", inst_valid_o); end
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h0020_8113, 32'h4}) begin errors++; $display("FAIL bp_inst1: got %0b/%h/%h want 1/00208113/4", inst_valid_o, inst_o, inst_addr_o); end
  endtask

  task automatic test_slow_mem();
    do_reset(3, 2);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_req_o, mem_gnt_i, mem_addr_o} !== {2'b10, 32'h0}) begin errors++; $display("FAIL slow_wait_gnt%0d: got req=%0b gnt=%0b addr=%h want 1/0/0", i, mem_req_o, mem_gnt_i, mem_addr_o); end
      next_cycle();
    end
    checks++; if ({mem_req_o, mem_gnt_i, mem_addr_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL slow_gnt: got req=%0b gnt=%0b addr=%h want 1/1/0", mem_req_o, mem_gnt_i, mem_addr_o); end
    id_ready_i = 1'b0;
    next_cycle();
    checks++; if ({mem_req_o, inst_valid_o} !== 2'b00) begin errors++; $display("FAIL slow_wait_rv: got req=%0b valid=%0b want 0/0", mem_req_o, inst_valid_o); end
    next_cycle();
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o, mem_addr_o} !== {1'b1, 32'h0010_0093, 32'h0, 32'h4}) begin errors++; $display("FAIL slow_inst: got %0b/%h/%h pc=%h want 1/00100093/0/4", inst_valid_o, inst_o, inst_addr_o, mem_addr_o); end
    repeat (3) next_cycle();
    checks++; if ({inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o} !== {1'b1, 32'h0, 1'b0, 32'h4}) begin errors++; $display("FAIL slow_single: got %0b/%h req=%0b pc=%h want 1/0/0/4", inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o); end
  endtask

  task automatic test_jump_wait();
    do_reset(0, 3);
    repeat (4) next_cycle();
    checks++; if ({inst_valid_o, inst_addr_o, mem_addr_o} !== {1'b1, 32'h0, 32'h4}) begin errors++; $display("FAIL jw_inst0: got %0b/%h pc=%h want 1/0/4", inst_valid_o, inst_addr_o, mem_addr_o); end
    repeat (4) next_cycle();
    checks++; if ({inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin errors++; $display("FAIL jw_req8: got %0b/%h req=%0b/%h want 1/4/1/8", inst_valid_o, inst_addr_o, mem_req_o, mem_addr_o); end
    next_cycle();
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++; if ({inst_valid_o, mem_req_o, mem_addr_o} !== {2'b00, 32'h100}) begin errors++; $display("FAIL jw_redirect: got valid=%0b req=%0b pc=%h want 0/0/100", inst_valid_o, mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if ({inst_valid_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL jw_drop_stale: got valid=%0b req=%0b want 0/0", inst_valid_o, mem_req_o); end
    next_cycle();
    checks++; if ({inst_valid_o, mem_req_o, mem_addr_o} !== {2'b01, 32'h100}) begin errors++; $display("FAIL jw_req100: got valid=%0b req=%0b addr=%h want 0/1/100", inst_valid_o, mem_req_o, mem_addr_o); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL jw_empty%0d: got %0b want 0", i, inst_valid_o); end
    end
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h0050_0293, 32'h100}) begin errors++; $display("FAIL jw_inst100: got %0b/%h/%h want 1/00500293/100", inst_valid_o, inst_o, inst_addr_o); end
  endtask

  task automatic test_jump_rvalid();
    do_reset(0, 1);
    next_cycle();
    jump_en_i = 1'b1; jump_addr_i = 32'h200; id_ready_i = 1'b1;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b0, NOP, 32'h0}) begin errors++; $display("FAIL jr_discard: got %0b/%h/%h want 0/%h/0", inst_valid_o, inst_o, inst_addr_o, NOP); end
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h200}) begin errors++; $display("FAIL jr_req: got %0b/%h want 1/200", mem_req_o, mem_addr_o); end
    next_cycle();
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h00a0_0513, 32'h200}) begin errors++; $display("FAIL jr_inst: got %0b/%h/%h want 1/00a00513/200", inst_valid_o, inst_o, inst_addr_o); end
  endtask

  task automatic test_jump_gnt();
    do_reset(0, 1);
    jump_en_i = 1'b1; jump_addr_i = 32'h300;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b0, 32'h300}) begin errors++; $display("FAIL jg_hold: got %0b/%h want 0/300", mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, 32'h300, 1'b0}) begin errors++; $display("FAIL jg_req: got %0b/%h valid=%0b want 1/300/0", mem_req_o, mem_addr_o, inst_valid_o); end
    next_cycle();
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h00c0_0613, 32'h300}) begin errors++; $display("FAIL jg_inst: got %0b/%h/%h want 1/00c00613/300", inst_valid_o, inst_o, inst_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset(0, 1);
    next_cycle();
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_req: got %0b/%h want 1/fffffffc", mem_req_o, mem_addr_o); end
    next_cycle();
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", mem_addr_o); end
    next_cycle();
    checks++; if ({inst_valid_o, inst_o, inst_addr_o} !== {1'b1, 32'h0000_0003, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_inst: got %0b/%h/%h want 1/00000003/fffffffc", inst_valid_o, inst_o, inst_addr_o); end
  endtask

  task automatic test_misalign();
    logic        exp_err;
    logic [31:0] exp_addr;
`ifdef IFU_MISALIGN_CHECK_EN
    exp_err  = 1'b1;
    exp_addr = 32'h100;
`else
    exp_err  = 1'b0;
    exp_addr = 32'h102;
`endif
    do_reset(0, 1);
    next_cycle();
    jump_en_i = 1'b1; jump_addr_i = 32'h102;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++; if ({fetch_err_o, mem_addr_o} !== {exp_err, exp_addr}) begin errors++; $display("FAIL mis_jump: got err=%0b addr=%h want %0b/%h", fetch_err_o, mem_addr_o, exp_err, exp_addr); end
    next_cycle();
    jump_en_i = 1'b1; jump_addr_i = 32'h200;
    #1;
    next_cycle();
    jump_en_i = 1'b0;
    repeat (2) next_cycle();
    checks++; if (fetch_err_o !== exp_err) begin errors++; $display("FAIL mis_sticky: got %0b want %0b", fetch_err_o, exp_err); end
    rst_n = 1'b0;
    #1;
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL mis_reset_clear: got %0b want 0", fetch_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_slow_mem();
    test_jump_wait();
    test_jump_rvalid();
    test_jump_gnt();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit feeding the if_id register, and through it the decoder, with inst and inst_addr.
- Owns the PC.
- Issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Holds one fetched instruction in an output register until downstream accepts it.
- Redirects on jump requests from the execute stage, discarding any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INST, 32'h0000_0013, value driven on inst_o while no valid instruction is held (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
jump_en_i  in  1  redirect request from execute stage; one-cycle pulse.
jump_addr_i  in  32  redirect target.
id_ready_i  in  1  downstream accepts inst_o this cycle.
mem_req_o  out  1  fetch request valid.
mem_addr_o  out  32  fetch address; always equal to pc.
mem_gnt_i  in  1  memory accepts request this cycle.
mem_rvalid_i  in  1  response data valid.
mem_rdata_i  in  32  response instruction word.
inst_o  out  32  held instruction, or NOP_INST when empty.
inst_addr_o  out  32  address of inst_o; 0 when empty.
inst_valid_o  out  1  output register holds a valid instruction.
fetch_err_o  out  1  misaligned jump target flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=S_REQ, pc=RESET_PC, drop=0.
  - inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, fetch_err_o=0.
  - mem_req_o low while in reset; high in first cycle after deassertion. Reset mid-transaction abandons it; a late rvalid after reset is ignored because state is S_REQ.
- States:
  - S_REQ: mem_req_o=1 if output slot free next cycle (inst_valid_o=0, or id_ready_i=1 this cycle), else 0. On mem_req_o&&mem_gnt_i: pc<=pc+4 (wraps mod 2^32), go to S_WAIT.
  - S_WAIT: mem_req_o=0. On mem_rvalid_i:
    - if drop=1: clear drop, discard data.
    - else: load inst_o<=mem_rdata_i, inst_addr_o<=pc-4, inst_valid_o<=1.
    - Either way go to S_REQ.
- Output consumption: inst_valid_o&&id_ready_i with no load that cycle -> inst_valid_o<=0, inst_o<=NOP_INST, inst_addr_o<=0. Load and consume in same cycle -> load wins.
- Timing:
  - Zero-wait memory (gnt same cycle, rvalid next cycle): first instruction valid 2 cycles after first req.
  - Sustained throughput is one instruction per 2 cycles.
  - inst_o/inst_addr_o/inst_valid_o are registered.
- Jump (jump_en_i=1) has priority over all other events that cycle:
  - pc<=jump_addr_i; state<=S_REQ.
  - inst_valid_o<=0, inst_o<=NOP_INST, inst_addr_o<=0; a simultaneous consume is irrelevant.
  - drop<=1 if state is S_WAIT without rvalid this cycle, or state is S_REQ with gnt this cycle. Otherwise drop<=0.
  - A response arriving in the jump cycle itself is discarded.
  - With drop set, a request to jump_addr_i is issued only after the dropped rvalid is consumed. This keeps a single outstanding request.
- No other flush/hold inputs; back-pressure only via id_ready_i.

Optional Feature:
Macro IFU_MISALIGN_CHECK_EN.
- Defined: jump with jump_addr_i[1:0]!=0 sets fetch_err_o=1 (sticky until reset). pc<=jump_addr_i with bits[1:0] forced to 0; fetch continues from there.
- Undefined: fetch_err_o tied 0; jump_addr_i used unmodified, low bits passed through to mem_addr_o.

Decomposition:
- Shared defines file: NOP encoding (INST_NOP), fetch state encodings (S_REQ, S_WAIT), 32-bit ZERO/width constants alongside the existing opcode defines.
- No sub-module; the output register is small enough to keep inline.

Test Plan:
- Reset then zero-wait memory returning 32'h00100093 at 0x0 and 32'h00208113 at 0x4, id_ready_i=1 -> mem_addr_o sequence 0x0,0x4,0x8; inst_o 32'h00100093 / inst_addr_o 0x0 valid 2 cycles after first req, next instruction 2 cycles later.
- id_ready_i=0 after first instruction loaded -> inst_o held at 32'h00100093, mem_req_o stays 0; raise id_ready_i -> req to 0x4 same cycle.
- Memory with 3-cycle gnt delay and 2-cycle rvalid delay -> mem_addr_o stable at 0x0 until gnt; exactly one response accepted; pc=0x4 afterwards.
- Jump to 0x100 while in S_WAIT for 0x8 -> response for 0x8 discarded; inst_valid_o=0 until 0x100 fetched; inst_addr_o=0x100 next.
- Jump in same cycle as rvalid and id_ready_i=1 -> data discarded, output NOP_INST with valid 0, next req addr = jump target.
- With IFU_MISALIGN_CHECK_EN, jump to 0x102 -> fetch_err_o=1, mem_addr_o=0x100; fetch_err_o stays 1 until rst_n low.
